// File: rtl/rect_batch_receiver.sv
`timescale 1ns/1ps
// Purpose: store a streamed rect frame (X0,X1,Y0,Y1,COLOR fields) in two ping-pong batch banks.
// Latency: a batch is presented the cycle after its last word is stored; rd_data lags rd_addr by 1 cycle.
// Backpressure: none upstream; a word arriving while the fill bank is still full is dropped and flagged.
module rect_batch_receiver #(
    parameter int DATA_WIDTH      = 16,
    parameter int RECTS_PER_BATCH = 16,
    parameter int BATCHES         = 4,
    parameter int FIELDS          = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  copy_start,
    input  logic                  din_valid,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [3:0]            rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  batch_valid,
    output logic [2:0]            batch_field,
    output logic [1:0]            batch_index,
    input  logic                  batch_done,
    output logic                  frame_done,
    output logic                  overflow
);

    localparam int             WW         = (RECTS_PER_BATCH > 1) ? $clog2(RECTS_PER_BATCH) : 1;
    localparam logic [WW-1:0]  LAST_WORD  = WW'(RECTS_PER_BATCH - 1);
    localparam logic [1:0]     LAST_BATCH = 2'(BATCHES - 1);
    localparam logic [2:0]     LAST_FIELD = 3'(FIELDS - 1);

    typedef enum logic {IDLE, FILL} state_t;

    state_t                state;
    state_t                state_next;

    logic [DATA_WIDTH-1:0] bank_mem [2][RECTS_PER_BATCH];
    logic [1:0]            bank_full;
    logic [2:0]            bank_field [2];
    logic [1:0]            bank_batch [2];

    logic                  fill_ptr;
    logic                  rd_ptr;
    logic [WW-1:0]         word_cnt;
    logic [1:0]            batch_cnt;
    logic [2:0]            field_cnt;
    logic [WW-1:0]         rd_idx;

    logic                  wr_en;
    logic                  batch_end;
    logic                  frame_end;
    logic                  rd_release;
    logic                  drop;

    // A word is only stored while filling and only into a bank the consumer has released.
    assign wr_en      = (state == FILL) && din_valid && !bank_full[fill_ptr];
    assign drop       = (state == FILL) && din_valid &&  bank_full[fill_ptr];
    assign batch_end  = wr_en && (word_cnt == LAST_WORD);
    assign frame_end  = batch_end && (batch_cnt == LAST_BATCH) && (field_cnt == LAST_FIELD);
    assign rd_release = batch_done && bank_full[rd_ptr];
    assign rd_idx     = WW'(rd_addr);

    assign batch_valid = bank_full[rd_ptr];
    assign batch_field = bank_field[rd_ptr];
    assign batch_index = bank_batch[rd_ptr];

    // Fill FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Fill FSM next state: start on copy_start, stop after the last word of the frame.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (copy_start) state_next = FILL;
            FILL:    if (frame_end)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Word / batch / field counters and the fill pointer; the pointer survives copy_start.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_cnt  <= '0;
            batch_cnt <= '0;
            field_cnt <= '0;
            fill_ptr  <= 1'b0;
        end else if (state == IDLE && copy_start) begin
            word_cnt  <= '0;
            batch_cnt <= '0;
            field_cnt <= '0;
        end else if (wr_en) begin
            if (batch_end) begin
                word_cnt <= '0;
                fill_ptr <= ~fill_ptr;
                if (batch_cnt == LAST_BATCH) begin
                    batch_cnt <= '0;
                    field_cnt <= (field_cnt == LAST_FIELD) ? 3'd0 : field_cnt + 3'd1;
                end else begin
                    batch_cnt <= batch_cnt + 2'd1;
                end
            end else begin
                word_cnt <= word_cnt + 1'b1;
            end
        end
    end

    // Bank flags and tags; completion and release always target different banks.
    always_ff @(posedge clk) begin
        if (reset) begin
            bank_full     <= 2'b00;
            bank_field[0] <= 3'd0;
            bank_field[1] <= 3'd0;
            bank_batch[0] <= 2'd0;
            bank_batch[1] <= 2'd0;
            rd_ptr        <= 1'b0;
        end else begin
            if (batch_end) begin
                bank_full[fill_ptr]  <= 1'b1;
                bank_field[fill_ptr] <= field_cnt;
                bank_batch[fill_ptr] <= batch_cnt;
            end
            if (rd_release) begin
                bank_full[rd_ptr] <= 1'b0;
                rd_ptr            <= ~rd_ptr;
            end
        end
    end

    // Bank storage; contents are qualified by the full flags so they need no reset.
    always_ff @(posedge clk) begin
        if (wr_en) bank_mem[fill_ptr][word_cnt] <= din;
    end

    // Registered read port, frame completion pulse and sticky drop flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data    <= '0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            rd_data    <= bank_mem[rd_ptr][rd_idx];
            frame_done <= frame_end;
            if (drop) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rect_batch_receiver.sv
`timescale 1ns/1ps
module tb_rect_batch_receiver;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          copy_start = 1'b0;
    logic          din_valid = 1'b0;
    logic [DW-1:0] din = '0;
    logic [3:0]    rd_addr = '0;
    logic [DW-1:0] rd_data;
    logic          batch_valid;
    logic [2:0]    batch_field;
    logic [1:0]    batch_index;
    logic          batch_done = 1'b0;
    logic          frame_done;
    logic          overflow;

    rect_batch_receiver #(
        .DATA_WIDTH(DW), .RECTS_PER_BATCH(16), .BATCHES(4), .FIELDS(5)
    ) dut (
        .clk(clk), .reset(reset), .copy_start(copy_start), .din_valid(din_valid),
        .din(din), .rd_addr(rd_addr), .rd_data(rd_data), .batch_valid(batch_valid),
        .batch_field(batch_field), .batch_index(batch_index), .batch_done(batch_done),
        .frame_done(frame_done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]            field;
        logic [1:0]            index;
        logic [15:0][DW-1:0]   data;
    } batch_t;

    batch_t q[$];
    batch_t cur;
    bit     m_fill;
    int     m_word, m_batch, m_field;
    bit     m_ovf, m_fd;
    int     n_cmp = 0;
    int     n_err = 0;
    int     fd_count = 0;

    // One clock: drive inputs at a falling edge, advance the model across the rising edge, check at the next falling edge.
    task automatic step(input logic vld, input logic [DW-1:0] d, input logic done,
                        input logic strt, input logic rst);
        bit acc;
        bit was_fill;
        bit exp_v;
        reset = rst; din_valid = vld; din = d; batch_done = done; copy_start = strt;
        @(negedge clk);
        m_fd = 0;
        if (rst) begin
            q.delete();
            m_fill = 0; m_word = 0; m_batch = 0; m_field = 0; m_ovf = 0;
        end else begin
            was_fill = m_fill;
            acc = was_fill && vld && (q.size() < 2);
            if (was_fill && vld && !acc) m_ovf = 1;
            if (done && q.size() > 0) void'(q.pop_front());
            if (acc) begin
                cur.data[m_word] = d;
                if (m_word == 15) begin
                    cur.field = 3'(m_field);
                    cur.index = 2'(m_batch);
                    q.push_back(cur);
                    m_word = 0;
                    if (m_batch == 3) begin
                        m_batch = 0;
                        if (m_field == 4) begin
                            m_field = 0; m_fill = 0; m_fd = 1;
                        end else begin
                            m_field++;
                        end
                    end else begin
                        m_batch++;
                    end
                end else begin
                    m_word++;
                end
            end
            if (strt && !was_fill) begin
                m_fill = 1; m_word = 0; m_batch = 0; m_field = 0;
            end
        end
        reset = 1'b0; din_valid = 1'b0; batch_done = 1'b0; copy_start = 1'b0;
        exp_v = (q.size() > 0);
        n_cmp++;
        if (batch_valid !== exp_v) begin
            n_err++; $display("FAIL step_batch_valid: got %b want %b at %0t", batch_valid, exp_v, $time);
        end
        if (exp_v) begin
            n_cmp++;
            if (batch_field !== q[0].field || batch_index !== q[0].index) begin
                n_err++;
                $display("FAIL step_tags: got (%0d,%0d) want (%0d,%0d) at %0t",
                         batch_field, batch_index, q[0].field, q[0].index, $time);
            end
        end
        n_cmp++;
        if (overflow !== m_ovf) begin
            n_err++; $display("FAIL step_overflow: got %b want %b at %0t", overflow, m_ovf, $time);
        end
        n_cmp++;
        if (frame_done !== m_fd) begin
            n_err++; $display("FAIL step_frame_done: got %b want %b at %0t", frame_done, m_fd, $time);
        end
        if (frame_done === 1'b1) fd_count++;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic put(input logic [DW-1:0] d);
        step(1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic start();
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        repeat (2) step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    // Pop the scoreboard head: read every word of the presented batch, then release it.
    task automatic consume(input string tag);
        if (q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL %s_present: batch_valid %b, no batch expected to be presented", tag, batch_valid);
            return;
        end
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i);
            idle(1);
            n_cmp++;
            if (rd_data !== q[0].data[i]) begin
                n_err++;
                $display("FAIL %s_rd_data[%0d]: got %h want %h", tag, i, rd_data, q[0].data[i]);
            end
        end
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (rd_data !== '0 || batch_field !== 3'd0 || batch_index !== 2'd0) begin
            n_err++;
            $display("FAIL reset_outputs: rd_data %h field %0d index %0d, want all 0", rd_data, batch_field, batch_index);
        end
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_gapped_batch();
        do_reset();
        start();
        for (int i = 0; i < 16; i++) begin
            put(16'h0100 + 16'(i));
            if (i < 15) idle(2);
        end
        n_cmp++;
        if (batch_valid !== 1'b1 || batch_field !== 3'd0 || batch_index !== 2'd0) begin
            n_err++;
            $display("FAIL gap_present: valid %b tags (%0d,%0d), want 1 (0,0)", batch_valid, batch_field, batch_index);
        end
        rd_addr = 4'd5;
        idle(1);
        n_cmp++;
        if (rd_data !== 16'h0105) begin
            n_err++; $display("FAIL gap_rd5: got %h want 0105", rd_data);
        end
        consume("gap");
    endtask

    task automatic test_overflow();
        do_reset();
        start();
        for (int i = 0; i < 33; i++) put(16'h2000 + 16'(i));
        n_cmp++;
        if (overflow !== 1'b1 || batch_index !== 2'd0) begin
            n_err++; $display("FAIL ovf_flag: overflow %b index %0d, want 1 and 0", overflow, batch_index);
        end
        consume("ovf");
        n_cmp++;
        if (batch_valid !== 1'b1 || batch_index !== 2'd1) begin
            n_err++; $display("FAIL ovf_next: valid %b index %0d, want 1 and 1", batch_valid, batch_index);
        end
        consume("ovf2");
    endtask

    task automatic test_full_frame();
        do_reset();
        fd_count = 0;
        start();
        for (int b = 0; b < 20; b++) begin
            for (int w = 0; w < 16; w++) put(16'h5A00 ^ 16'(b * 16 + w));
            idle(10);
            n_cmp++;
            if (batch_valid !== 1'b1 || batch_field !== 3'(b / 4) || batch_index !== 2'(b % 4)) begin
                n_err++;
                $display("FAIL frame_order[%0d]: valid %b tags (%0d,%0d) want (%0d,%0d)",
                         b, batch_valid, batch_field, batch_index, b / 4, b % 4);
            end
            consume("frame");
        end
        n_cmp++;
        if (fd_count != 1) begin
            n_err++; $display("FAIL frame_done_count: got %0d want 1", fd_count);
        end
        put(16'hDEAD);
        idle(1);
        n_cmp++;
        if (batch_valid !== 1'b0 || overflow !== 1'b0) begin
            n_err++; $display("FAIL frame_idle: valid %b overflow %b, want 0 0", batch_valid, overflow);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        start();
        for (int i = 0; i < 31; i++) put(16'h3000 + 16'(i));
        step(1'b1, 16'h3F0F, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (batch_valid !== 1'b1 || batch_field !== 3'd0 || batch_index !== 2'd1) begin
            n_err++;
            $display("FAIL same_cycle: valid %b tags (%0d,%0d), want 1 (0,1)", batch_valid, batch_field, batch_index);
        end
        consume("same");
    endtask

    task automatic test_reset_mid();
        do_reset();
        start();
        for (int i = 0; i < 24; i++) put(16'h4000 + 16'(i));
        do_reset();
        n_cmp++;
        if (batch_valid !== 1'b0 || overflow !== 1'b0) begin
            n_err++; $display("FAIL mid_reset: valid %b overflow %b, want 0 0", batch_valid, overflow);
        end
        start();
        for (int i = 0; i < 16; i++) put(16'h4100 + 16'(i));
        n_cmp++;
        if (batch_valid !== 1'b1 || batch_field !== 3'd0 || batch_index !== 2'd0) begin
            n_err++;
            $display("FAIL mid_restart: valid %b tags (%0d,%0d), want 1 (0,0)", batch_valid, batch_field, batch_index);
        end
        consume("mid");
    endtask

    task automatic test_ignored();
        do_reset();
        put(16'h7777);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (batch_valid !== 1'b0 || overflow !== 1'b0) begin
            n_err++; $display("FAIL ignored_idle: valid %b overflow %b, want 0 0", batch_valid, overflow);
        end
        start();
        for (int i = 0; i < 5; i++) put(16'h6000 + 16'(i));
        start();
        for (int i = 5; i < 16; i++) put(16'h6000 + 16'(i));
        n_cmp++;
        if (batch_valid !== 1'b1 || batch_field !== 3'd0 || batch_index !== 2'd0) begin
            n_err++;
            $display("FAIL ignored_start: valid %b tags (%0d,%0d), want 1 (0,0)", batch_valid, batch_field, batch_index);
        end
        consume("ign");
    endtask

    initial begin
        test_reset();
        test_gapped_batch();
        test_overflow();
        test_full_frame();
        test_same_cycle();
        test_reset_mid();
        test_ignored();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
